vector_logic_lane_unit: RTL and testbench

VECTOR_LOGIC_LANE_UNIT -- requirements
Module: vector_logic_lane_unit

---
 rtl/vector_logic_lane_unit.sv | 203 ++++++++++++++++++++
 tb/tb_vector_logic_lane_unit.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_logic_lane_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// vector_logic_lane_unit
//
// Purpose:
//   Bitwise vector logic unit. A request latches two VLEN-bit operands, the
//   prior destination value and an optional byte mask. The result is then
//   produced one LANE_WIDTH slice per cycle (BEATS = VLEN/LANE_WIDTH cycles)
//   and held on vd until the consumer takes it.
//
// Handshake:
//   A request is accepted on a rising edge where in_valid && in_ready.
//   A result is consumed on a rising edge where out_valid && out_ready.
//   in_ready is high only while idle and out_valid only while a finished
//   result is held; both depend only on the state register, never on the
//   inputs, so neither side can combinationally loop through this unit.
//
// Ports:
//   clock        sole clock, all state on the rising edge
//   reset        synchronous, active-high
//   in_valid     operation request
//   in_ready     unit can accept a request (idle)
//   logic_mode   000 zero, 001 AND, 010 OR, 011 XOR, 100 NAND, 101 NOR,
//                110 XNOR, 111 ANDN (vs2 & ~vs1)
//   mask_enable  apply v0_mask when high
//   v0_mask      per-byte write enable (1 = write result byte)
//   vs2, vs1     operands
//   vd_old       prior destination value, kept in masked-off bytes
//   out_valid    result held on vd
//   out_ready    consumer accepts result
//   vd           result vector
//   state_dbg    current FSM state (0 idle, 1 busy, 2 done)
// ---------------------------------------------------------------------------
module vector_logic_lane_unit #(
    parameter int VLEN       = 128,
    parameter int LANE_WIDTH = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        logic_mode,
    input  logic              mask_enable,
    input  logic [VLEN/8-1:0] v0_mask,
    input  logic [VLEN-1:0]   vs2,
    input  logic [VLEN-1:0]   vs1,
    input  logic [VLEN-1:0]   vd_old,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [VLEN-1:0]   vd,
    output logic [1:0]        state_dbg
);

    localparam int BEATS      = VLEN / LANE_WIDTH;
    localparam int LANE_BYTES = LANE_WIDTH / 8;
    // Keep the counter at least one bit wide so BEATS = 1 still elaborates.
    localparam int BW         = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q,   state_d;
    logic [BW-1:0]       beat_q,    beat_d;
    logic [2:0]          mode_q,    mode_d;
    logic                mask_en_q, mask_en_d;
    logic [VLEN/8-1:0]   mask_q,    mask_d;
    logic [VLEN-1:0]     vs2_q,     vs2_d;
    logic [VLEN-1:0]     vs1_q,     vs1_d;
    logic [VLEN-1:0]     old_q,     old_d;
    logic [VLEN-1:0]     vd_q,      vd_d;

    logic [LANE_WIDTH-1:0] lane_a;
    logic [LANE_WIDTH-1:0] lane_b;
    logic [LANE_WIDTH-1:0] lane_old;
    logic [LANE_BYTES-1:0] lane_m;
    logic [LANE_WIDTH-1:0] lane_res;
    logic [LANE_WIDTH-1:0] lane_out;

    // Pick the latched slice addressed by the beat counter. Only one
    // LANE_WIDTH-wide logic datapath exists; it is shared across beats.
    always_comb begin
        lane_a   = '0;
        lane_b   = '0;
        lane_old = '0;
        lane_m   = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_q == BW'(b)) begin
                lane_a   = vs2_q[b*LANE_WIDTH +: LANE_WIDTH];
                lane_b   = vs1_q[b*LANE_WIDTH +: LANE_WIDTH];
                lane_old = old_q[b*LANE_WIDTH +: LANE_WIDTH];
                lane_m   = mask_q[b*LANE_BYTES +: LANE_BYTES];
            end
        end
    end

    always_comb begin
        lane_res = '0;
        case (mode_q)
            3'b000:  lane_res = '0;
            3'b001:  lane_res = lane_a & lane_b;
            3'b010:  lane_res = lane_a | lane_b;
            3'b011:  lane_res = lane_a ^ lane_b;
            3'b100:  lane_res = ~(lane_a & lane_b);
            3'b101:  lane_res = ~(lane_a | lane_b);
            3'b110:  lane_res = ~(lane_a ^ lane_b);
            3'b111:  lane_res = lane_a & ~lane_b;
            default: lane_res = '0;
        endcase
    end

    // Masked-off bytes keep the latched prior destination value.
    always_comb begin
        lane_out = '0;
        for (int i = 0; i < LANE_BYTES; i++) begin
            lane_out[i*8 +: 8] = (!mask_en_q || lane_m[i]) ? lane_res[i*8 +: 8]
                                                           : lane_old[i*8 +: 8];
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        mode_d    = mode_q;
        mask_en_d = mask_en_q;
        mask_d    = mask_q;
        vs2_d     = vs2_q;
        vs1_d     = vs1_q;
        old_d     = old_q;
        vd_d      = vd_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mode_d    = logic_mode;
                    mask_en_d = mask_enable;
                    mask_d    = v0_mask;
                    vs2_d     = vs2;
                    vs1_d     = vs1;
                    old_d     = vd_old;
                    beat_d    = '0;
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                for (int b = 0; b < BEATS; b++) begin
                    if (beat_q == BW'(b)) begin
                        vd_d[b*LANE_WIDTH +: LANE_WIDTH] = lane_out;
                    end
                end
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    state_d = S_DONE;
                end else begin
                    beat_d  = beat_q + BW'(1);
                end
            end
            S_DONE: begin
                // Returning to idle here means the handshake edge can never
                // also accept; the earliest new accept is the next edge.
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            beat_q    <= '0;
            mode_q    <= '0;
            mask_en_q <= 1'b0;
            mask_q    <= '0;
            vs2_q     <= '0;
            vs1_q     <= '0;
            old_q     <= '0;
            vd_q      <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            mode_q    <= mode_d;
            mask_en_q <= mask_en_d;
            mask_q    <= mask_d;
            vs2_q     <= vs2_d;
            vs1_q     <= vs1_d;
            old_q     <= old_d;
            vd_q      <= vd_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign vd        = vd_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_vector_logic_lane_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_vector_logic_lane_unit
//
// Bench for vector_logic_lane_unit at VLEN=128, LANE_WIDTH=32. A reference
// model computes each whole-vector result directly from the operation table
// and tracks when the result must appear and be held; a compare process
// checks the outputs against it every cycle. Directed tests add literal
// expectations for the fixed vectors.
// ---------------------------------------------------------------------------
module tb_vector_logic_lane_unit;

    localparam int VLEN  = 128;
    localparam int LW    = 32;
    localparam int BEATS = VLEN / LW;
    localparam int NB    = VLEN / 8;

    // ---------------- clock / reset / DUT ----------------
    logic            clock = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      logic_mode;
    logic            mask_enable;
    logic [NB-1:0]   v0_mask;
    logic [VLEN-1:0] vs2, vs1, vd_old;
    logic            out_valid;
    logic            out_ready;
    logic [VLEN-1:0] vd;
    logic [1:0]      state_dbg;

    always #5 clock = ~clock;

    vector_logic_lane_unit #(.VLEN(VLEN), .LANE_WIDTH(LW)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .logic_mode  (logic_mode),
        .mask_enable (mask_enable),
        .v0_mask     (v0_mask),
        .vs2         (vs2),
        .vs1         (vs1),
        .vd_old      (vd_old),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .vd          (vd),
        .state_dbg   (state_dbg)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit chk_en   = 0;

    task automatic check(input string name, input logic [VLEN-1:0] act,
                         input logic [VLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [VLEN-1:0] model_result(
        input logic [2:0] mode, input logic men, input logic [NB-1:0] mask,
        input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
        input logic [VLEN-1:0] old);
        logic [VLEN-1:0] r;
        case (mode)
            3'd1:    r = a & b;
            3'd2:    r = a | b;
            3'd3:    r = a ^ b;
            3'd4:    r = ~(a & b);
            3'd5:    r = ~(a | b);
            3'd6:    r = ~(a ^ b);
            3'd7:    r = a & ~b;
            default: r = '0;
        endcase
        for (int i = 0; i < NB; i++)
            if (men && !mask[i]) r[i*8 +: 8] = old[i*8 +: 8];
        return r;
    endfunction

    logic [VLEN-1:0] exp_q[$];
    int              m_left = 0;     // cycles until the result is complete
    bit              m_done = 0;     // result is being offered
    logic [VLEN-1:0] m_cur  = '0;
    logic [VLEN-1:0] m_vd   = '0;    // what vd must show when not busy

    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            m_left = 0;
            m_done = 0;
            m_vd   = '0;
            exp_q.delete();
        end else if (m_done) begin
            if (out_ready) m_done = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1;
                m_vd   = m_cur;
            end
        end else if (in_valid) begin
            m_cur = model_result(logic_mode, mask_enable, v0_mask, vs2, vs1, vd_old);
            exp_q.push_back(m_cur);
            m_left = BEATS;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clock) begin
        if (chk_en && !reset) begin
            check("in_ready", in_ready, (m_left == 0 && !m_done));
            check("out_valid", out_valid, m_done);
            if (m_left == 0) check("vd_hold", vd, m_vd);
            if (m_done && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_empty: got result %h expected none queued", vd);
                end else begin
                    check("sb_vd", vd, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input logic [2:0] mode, input logic men,
                           input logic [NB-1:0] mask, input logic [VLEN-1:0] a,
                           input logic [VLEN-1:0] b, input logic [VLEN-1:0] old);
        logic_mode  = mode;
        mask_enable = men;
        v0_mask     = mask;
        vs2         = a;
        vs1         = b;
        vd_old      = old;
    endtask

    task automatic rand_inputs();
        logic_mode  = 3'($urandom_range(0, 7));
        mask_enable = 1'($urandom_range(0, 1));
        v0_mask     = 16'($urandom);
        vs2         = {$urandom, $urandom, $urandom, $urandom};
        vs1         = {$urandom, $urandom, $urandom, $urandom};
        vd_old      = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Wait for idle, accept the request already set up, wait for the result.
    task automatic send_and_wait(output int lat, output logic [VLEN-1:0] res);
        int guard = 0;
        int acc;
        in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("accept_ready", in_ready, 1'b1);
        tick();
        acc      = cyc;
        in_valid = 1'b0;
        rand_inputs();   // must be ignored while busy
        guard = 0;
        while (!out_valid && guard < 50) begin
            tick();
            guard++;
        end
        check("done_seen", out_valid, 1'b1);
        lat = cyc - acc;
        res = vd;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // ---------------- directed tests ----------------
    logic [15:0] mode_tbl [8] = '{16'h0000, 16'hF000, 16'hFFF0, 16'h0FF0,
                                  16'h0FFF, 16'h000F, 16'hF00F, 16'h00F0};

    initial begin
        int              lat;
        int              guard;
        int              acc [3];
        logic [VLEN-1:0] res;
        logic [VLEN-1:0] held;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_req(3'd0, 1'b0, '0, '0, '0, '0);
        tick();
        tick();
        chk_en = 1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_vd", vd, '0);
        reset = 1'b0;

        // XOR, no mask
        set_req(3'd3, 1'b0, '0, {16{8'hA5}}, {16{8'hFF}}, '0);
        send_and_wait(lat, res);
        check("xor_latency", lat, BEATS);
        check("xor_vd", res, {16{8'h5A}});
        handshake();

        // AND with byte mask: low 8 bytes written, high 8 keep vd_old
        set_req(3'd1, 1'b1, 16'h00FF, {16{8'hFF}}, {16{8'hFF}}, {16{8'h11}});
        send_and_wait(lat, res);
        check("mask_latency", lat, BEATS);
        check("mask_vd", res, 128'h1111_1111_1111_1111_FFFF_FFFF_FFFF_FFFF);
        handshake();

        // every mode on the F0F0 / FF00 pattern
        for (int m = 0; m < 8; m++) begin
            set_req(3'(m), 1'b0, '0, {8{16'hF0F0}}, {8{16'hFF00}}, '0);
            send_and_wait(lat, res);
            check($sformatf("mode%0d_lo16", m), res[15:0], mode_tbl[m]);
            handshake();
        end

        // stall in done with in_valid high and inputs changing
        rand_inputs();
        mask_enable = 1'b1;
        send_and_wait(lat, res);
        held = res;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            rand_inputs();
            tick();
            check("stall_vd", vd, held);
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        tick();                       // handshake edge with in_valid still high
        out_ready = 1'b0;
        check("no_accept_on_handshake", in_ready, 1'b1);
        check("idle_after_handshake", out_valid, 1'b0);
        tick();                       // earliest accept
        check("accept_next_edge", in_ready, 1'b0);
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 50) begin
            tick();
            guard++;
        end
        check("stall_next_done", out_valid, 1'b1);
        handshake();

        // reset on the edge that would process beat 2
        rand_inputs();
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        tick();                       // accept
        in_valid = 1'b0;
        tick();                       // beat 0
        tick();                       // beat 1
        reset = 1'b1;
        tick();                       // beat 2 abandoned
        reset = 1'b0;
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_vd", vd, '0);
        set_req(3'd2, 1'b1, 16'hF0F0, {16{8'h0F}}, {16{8'h30}}, {16{8'hC3}});
        send_and_wait(lat, res);
        check("postrst_latency", lat, BEATS);
        check("postrst_vd", res, 128'h3F3F3F3F_C3C3C3C3_3F3F3F3F_C3C3C3C3);
        handshake();

        // back-to-back with out_ready tied high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        rand_inputs();
        logic_mode = 3'd1;
        for (int i = 0; i < 3; i++) begin
            guard = 0;
            while (!in_ready && guard < 50) begin
                tick();
                guard++;
            end
            check("b2b_ready", in_ready, 1'b1);
            tick();
            acc[i] = cyc;
            if (i < 2) begin
                rand_inputs();
                logic_mode = (i == 0) ? 3'd5 : 3'd7;
            end else begin
                in_valid = 1'b0;
            end
        end
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("b2b_drain", in_ready, 1'b1);
        check("b2b_gap01", acc[1] - acc[0], BEATS + 2);
        check("b2b_gap12", acc[2] - acc[1], BEATS + 2);
        check("b2b_sb_empty", exp_q.size(), 0);
        out_ready = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
